// File: rtl/coin_vend_ctrl_if.sv
// Coin-sense / actuator bundle for the vending controller; master drives coins and
// requests, slave (the controller) drives the registered dispense/return/status outputs.
interface coin_vend_ctrl_if #(
   parameter int CREDIT_W = 4
);
   logic                coin_q_i;
   logic                coin_d_i;
   logic                coin_n_i;
   logic                cancel_i;
   logic                restock_i;
   logic                release_o;
   logic                ret_q_o;
   logic                ret_d_o;
   logic                ret_n_o;
   logic                coin_rej_o;
   logic                busy_o;
   logic                sold_out_o;
   logic [CREDIT_W-1:0] credit_o;

   modport master (
      output coin_q_i, coin_d_i, coin_n_i, cancel_i, restock_i,
      input  release_o, ret_q_o, ret_d_o, ret_n_o, coin_rej_o, busy_o, sold_out_o, credit_o
   );

   modport slave (
      input  coin_q_i, coin_d_i, coin_n_i, cancel_i, restock_i,
      output release_o, ret_q_o, ret_d_o, ret_n_o, coin_rej_o, busy_o, sold_out_o, credit_o
   );
endinterface

// File: rtl/coin_vend_ctrl.sv
// Vending controller: credit accumulation, one-cycle release, greedy one-coin-per-cycle change.
// Release one cycle after the completing coin; coins offered while busy or sold out are rejected.
module coin_vend_ctrl #(
   parameter int PRICE      = 7,
   parameter int CREDIT_W   = 4,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 10
) (
   input logic              clk,
   input logic              rst_n,
   coin_vend_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_e;

   localparam logic [CREDIT_W:0]  PRICE_W      = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0]  VAL_Q        = (CREDIT_W+1)'(5);
   localparam logic [CREDIT_W:0]  VAL_D        = (CREDIT_W+1)'(2);
   localparam logic [CREDIT_W:0]  VAL_N        = (CREDIT_W+1)'(1);
   localparam logic [STOCK_W-1:0] STOCK_INIT_W = STOCK_W'(STOCK_INIT);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [STOCK_W-1:0]  stock_q, stock_d;
   logic                coin_rej_q, coin_rej_d;

   logic [CREDIT_W:0]   coin_val;
   logic                coin_any;
   logic [CREDIT_W:0]   credit_ext;
   logic [CREDIT_W:0]   total;
   logic [CREDIT_W:0]   after_price;
   logic [CREDIT_W:0]   ret_val;
   logic [CREDIT_W:0]   after_ret;
   logic                ge_q;
   logic                ge_d;
   logic                sold_out;

   // Only the highest-valued simultaneous coin counts; lower ones vanish silently.
   always_comb begin
      coin_val = '0;
      if (bus.coin_q_i) begin
         coin_val = VAL_Q;
      end else if (bus.coin_d_i) begin
         coin_val = VAL_D;
      end else if (bus.coin_n_i) begin
         coin_val = VAL_N;
      end
   end

   assign coin_any    = (coin_val != '0);
   assign credit_ext  = {1'b0, credit_q};
   assign total       = credit_ext + coin_val;
   assign after_price = total - PRICE_W;
   assign ge_q        = (credit_ext >= VAL_Q);
   assign ge_d        = (credit_ext >= VAL_D);
   assign ret_val     = ge_q ? VAL_Q : (ge_d ? VAL_D : VAL_N);
   assign after_ret   = credit_ext - ret_val;
   assign sold_out    = (stock_q == '0);

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      stock_d    = stock_q;
      coin_rej_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cancel_i && (credit_q != '0)) begin
               state_d    = CHANGE;
               coin_rej_d = coin_any;
            end else if (coin_any && sold_out) begin
               coin_rej_d = 1'b1;
            end else if (coin_any) begin
               if (total < PRICE_W) begin
                  credit_d = total[CREDIT_W-1:0];
               end else begin
                  credit_d = after_price[CREDIT_W-1:0];
                  stock_d  = stock_q - 1'b1;
                  state_d  = VEND;
               end
            end
         end
         VEND: begin
            coin_rej_d = coin_any;
            state_d    = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            coin_rej_d = coin_any;
            credit_d   = after_ret[CREDIT_W-1:0];
            if (after_ret == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (bus.restock_i) begin
         stock_d = STOCK_INIT_W;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         credit_q   <= '0;
         stock_q    <= STOCK_INIT_W;
         coin_rej_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         stock_q    <= stock_d;
         coin_rej_q <= coin_rej_d;
      end
   end

   // Outputs depend on registered state only, so actuators never see an input glitch.
   assign bus.release_o  = (state_q == VEND);
   assign bus.ret_q_o    = (state_q == CHANGE) && ge_q;
   assign bus.ret_d_o    = (state_q == CHANGE) && !ge_q && ge_d;
   assign bus.ret_n_o    = (state_q == CHANGE) && !ge_d;
   assign bus.coin_rej_o = coin_rej_q;
   assign bus.busy_o     = (state_q != IDLE);
   assign bus.sold_out_o = sold_out;
   assign bus.credit_o   = credit_q;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Bench for coin_vend_ctrl: directed scenarios with literal expectations, then randomized
// traffic scored against a purchase/refund model that keeps pending change as a coin list.
module tb_coin_vend_ctrl;
   localparam int PRICE      = 7;
   localparam int CREDIT_W   = 4;
   localparam int STOCK_W    = 4;
   localparam int STOCK_INIT = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   coin_vend_ctrl_if #(.CREDIT_W(CREDIT_W)) vif ();

   coin_vend_ctrl #(
      .PRICE      (PRICE),
      .CREDIT_W   (CREDIT_W),
      .STOCK_W    (STOCK_W),
      .STOCK_INIT (STOCK_INIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif.slave)
   );

   // Model: credit held, stock left, a pending release, and the change still owed as coins.
   int m_credit;
   int m_stock;
   bit m_rel;
   bit m_rej;
   int m_chg[$];

   function automatic void load_change(input int amount);
      int c = amount;
      while (c > 0) begin
         if (c >= 5) begin
            m_chg.push_back(5); c -= 5;
         end else if (c >= 2) begin
            m_chg.push_back(2); c -= 2;
         end else begin
            m_chg.push_back(1); c -= 1;
         end
      end
   endfunction

   // Vector layout: release, ret_q, ret_d, ret_n, coin_rej, busy, sold_out, credit[3:0]
   function automatic logic [10:0] exp_vec();
      bit in_chg = !m_rel && (m_chg.size() > 0);
      bit rq = in_chg && (m_chg[0] == 5);
      bit rd = in_chg && (m_chg[0] == 2);
      bit rn = in_chg && (m_chg[0] == 1);
      bit bz = m_rel || (m_chg.size() > 0);
      return {m_rel, rq, rd, rn, m_rej, bz, (m_stock == 0), 4'(m_credit)};
   endfunction

   function automatic logic [10:0] obs_vec();
      return {vif.release_o, vif.ret_q_o, vif.ret_d_o, vif.ret_n_o, vif.coin_rej_o,
              vif.busy_o, vif.sold_out_o, vif.credit_o};
   endfunction

   task automatic drive(input bit q, input bit d, input bit n, input bit c, input bit r);
      vif.coin_q_i  = q;
      vif.coin_d_i  = d;
      vif.coin_n_i  = n;
      vif.cancel_i  = c;
      vif.restock_i = r;
   endtask

   // One clock: inputs are stable before the edge, model advances at the edge, sample #1 later.
   task automatic step();
      bit q = vif.coin_q_i, d = vif.coin_d_i, n = vif.coin_n_i;
      bit c = vif.cancel_i, r = vif.restock_i, rs = rst_n;
      int v = q ? 5 : (d ? 2 : (n ? 1 : 0));
      bit bz;
      @(posedge clk);
      if (!rs) begin
         m_credit = 0; m_stock = STOCK_INIT; m_rel = 0; m_rej = 0; m_chg.delete();
      end else begin
         bz = m_rel || (m_chg.size() > 0);
         m_rej = 0;
         if (bz) begin
            m_rej = (v > 0);
            if (m_rel) m_rel = 0;
            else m_credit -= m_chg.pop_front();
         end else if (c && m_credit > 0) begin
            load_change(m_credit);
            m_rej = (v > 0);
         end else if (v > 0 && m_stock == 0) begin
            m_rej = 1;
         end else if (v > 0) begin
            if (m_credit + v < PRICE) begin
               m_credit += v;
            end else begin
               m_credit = m_credit + v - PRICE;
               m_stock -= 1;
               m_rel = 1;
               load_change(m_credit);
            end
         end
         if (r) m_stock = STOCK_INIT;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1, 0, 1, 1, 0);
      step();
      step();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== 11'h000) begin
         failures++;
         $display("FAIL reset_state got=%h want=000", obs_vec());
      end
      step();
      checks++;
      if (obs_vec() !== 11'h000) begin
         failures++;
         $display("FAIL reset_idle got=%h want=000", obs_vec());
      end
   endtask

   task automatic test_exact_price();
      logic [10:0] want[4] = '{11'h005, 11'h005, 11'h420, 11'h000};
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1, 0, 0, 0, 0);
         else if (i == 2) drive(0, 1, 0, 0, 0);
         else drive(0, 0, 0, 0, 0);
         step();
         checks++;
         if (obs_vec() !== want[i]) begin
            failures++;
            $display("FAIL exact_price[%0d] got=%h want=%h", i, obs_vec(), want[i]);
         end
      end
   endtask

   task automatic test_change();
      logic [10:0] want[5] = '{11'h005, 11'h423, 11'h123, 11'h0A1, 11'h000};
      for (int i = 0; i < 5; i++) begin
         if (i < 2) drive(1, 0, 0, 0, 0);
         else drive(0, 0, 0, 0, 0);
         step();
         checks++;
         if (obs_vec() !== want[i]) begin
            failures++;
            $display("FAIL change[%0d] got=%h want=%h", i, obs_vec(), want[i]);
         end
      end
   endtask

   task automatic test_cancel();
      logic [10:0] want[5] = '{11'h002, 11'h003, 11'h163, 11'h0A1, 11'h000};
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(0, 1, 0, 0, 0);
            1: drive(0, 0, 1, 0, 0);
            2: drive(1, 0, 0, 1, 0);
            default: drive(0, 0, 0, 0, 0);
         endcase
         step();
         checks++;
         if (obs_vec() !== want[i]) begin
            failures++;
            $display("FAIL cancel[%0d] got=%h want=%h", i, obs_vec(), want[i]);
         end
      end
   endtask

   task automatic test_priority_busy_reject();
      logic [10:0] want[5] = '{11'h005, 11'h423, 11'h123, 11'h0E1, 11'h000};
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(1, 1, 1, 0, 0);
            1: drive(1, 0, 0, 0, 0);
            3: drive(0, 0, 1, 0, 0);
            default: drive(0, 0, 0, 0, 0);
         endcase
         step();
         checks++;
         if (obs_vec() !== want[i]) begin
            failures++;
            $display("FAIL priority_busy[%0d] got=%h want=%h", i, obs_vec(), want[i]);
         end
      end
   endtask

   task automatic test_reset_mid_change();
      drive(1, 0, 0, 0, 0);
      step();
      step();
      drive(0, 0, 0, 0, 0);
      step();
      checks++;
      if (obs_vec() !== 11'h123) begin
         failures++;
         $display("FAIL mid_change_pre got=%h want=123", obs_vec());
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (obs_vec() !== 11'h000) begin
         failures++;
         $display("FAIL mid_change_reset got=%h want=000", obs_vec());
      end
   endtask

   task automatic test_sold_out();
      int guard = 0;
      while (m_stock > 0 && guard < 40) begin
         guard++;
         drive(1, 0, 0, 0, 0); step();
         drive(0, 0, 0, 0, 0); step();
         drive(0, 1, 0, 0, 0); step();
         drive(0, 0, 0, 0, 0); step();
      end
      checks++;
      if (obs_vec() !== 11'h010) begin
         failures++;
         $display("FAIL sold_out_flag got=%h want=010", obs_vec());
      end
      drive(0, 0, 1, 0, 0); step();
      checks++;
      if (obs_vec() !== 11'h050) begin
         failures++;
         $display("FAIL sold_out_reject got=%h want=050", obs_vec());
      end
      drive(0, 0, 0, 1, 0); step();
      checks++;
      if (obs_vec() !== 11'h010) begin
         failures++;
         $display("FAIL sold_out_cancel0 got=%h want=010", obs_vec());
      end
      drive(0, 0, 0, 0, 1); step();
      checks++;
      if (obs_vec() !== 11'h000) begin
         failures++;
         $display("FAIL restock got=%h want=000", obs_vec());
      end
      drive(0, 0, 1, 0, 0); step();
      checks++;
      if (obs_vec() !== 11'h001) begin
         failures++;
         $display("FAIL after_restock_nickel got=%h want=001", obs_vec());
      end
      drive(0, 0, 0, 1, 0); step();
      drive(0, 0, 0, 0, 0); step();
   endtask

   task automatic test_random();
      logic [10:0] want;
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 249) != 0);
         drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
         step();
         want = exp_vec();
         checks++;
         if (obs_vec() !== want) begin
            failures++;
            $display("FAIL random[%0d] got=%h want=%h", i, obs_vec(), want);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      m_credit = 0; m_stock = STOCK_INIT; m_rel = 0; m_rej = 0;
      drive(0, 0, 0, 0, 0);
      test_reset();
      test_exact_price();
      test_change();
      test_cancel();
      test_priority_busy_reject();
      test_reset_mid_change();
      test_sold_out();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/coin_vend_ctrl.md
Name: coin_vend_ctrl

Overview:
- Parametrised coin-accepting vending controller for the newspaper/vending family.
- Accumulates nickel, dime and quarter credit against a programmable price and issues a one-cycle release.
- Returns change one coin per cycle using greedy selection; supports customer cancel/refund and an inventory counter with sold-out lockout.
- Sits between the coin-sense front end and the dispense/coin-return actuators.

Parameters:
- PRICE, 7, item price in 5-cent units (7 = 35c); legal range 1..2^CREDIT_W-5.
- CREDIT_W, 4, credit register width; must hold PRICE+4.
- STOCK_W, 4, inventory counter width.
- STOCK_INIT, 10, inventory loaded at reset; must be ≤ 2^STOCK_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- coin_q  in  1  quarter inserted this cycle (5 units).
- coin_d  in  1  dime inserted this cycle (2 units).
- coin_n  in  1  nickel inserted this cycle (1 unit).
- cancel  in  1  refund request.
- restock  in  1  reload inventory to STOCK_INIT.
- release  out  1  dispense item, one-cycle pulse.
- ret_q  out  1  return one quarter this cycle.
- ret_d  out  1  return one dime this cycle.
- ret_n  out  1  return one nickel this cycle.
- coin_rej  out  1  coin not accepted; divert to return chute (one-cycle pulse).
- busy  out  1  high in VEND or CHANGE.
- sold_out  out  1  stock == 0.
- credit  out  CREDIT_W  current credit in units.

Behaviour:
- Reset: when rst_n=0 at a rising edge: state=IDLE, credit=0, stock=STOCK_INIT. All pulse outputs are 0 in the following cycle. Reset overrides every other input, including mid-VEND or mid-CHANGE; any undelivered change is discarded.
- Output decoding: release, ret_*, busy and sold_out are decoded from registered state only, with no combinational input path. coin_rej is a registered pulse.
- Coin priority: if several coin inputs are high in one cycle, only the highest value (Q>D>N) is considered. The others are ignored: no credit and no coin_rej.
- States:
  - IDLE:
    - cancel=1 with credit>0: go to CHANGE (refund all credit, no release). A coin in the same cycle is rejected (coin_rej next cycle).
    - cancel=1 with credit=0: no effect.
    - Coin with sold_out=1: coin_rej pulse, credit unchanged.
    - Otherwise, for a coin of value v: let t=credit+v.
      - If t<PRICE: credit<=t, stay in IDLE.
      - If t≥PRICE: credit<=t-PRICE, stock<=stock-1, go to VEND.
  - VEND (exactly 1 cycle): release=1. Next state is CHANGE if credit>0, else IDLE.
  - CHANGE: each cycle exactly one ret_* is high, selected greedily on the current credit:
    - credit≥5 → ret_q; else credit≥2 → ret_d; else ret_n.
    - credit is decremented by the returned value at the cycle end.
    - Go to IDLE when the result is 0.
- Latency: a coin sampled at edge k that completes the price produces release high in cycle k→k+1. The first change coin appears in cycle k+1→k+2.
- Coins arriving while busy=1 are rejected (coin_rej in the next cycle, credit unaffected). cancel is ignored while busy.
- restock: loads stock=STOCK_INIT at the edge in any state. If it coincides with the VEND-entry decrement, restock wins (stock=STOCK_INIT).
- sold_out becomes 1 the cycle after the last item's VEND entry. Credit remaining at sold-out stays refundable via cancel.
- Width rules: all arithmetic is in CREDIT_W+1 bits. Credit never exceeds PRICE+4, so no saturation logic is required. Stock never decrements below 0, guaranteed by the lockout.

Test Plan:
- PRICE=7: Q at cycle 1, D at cycle 3 → release high cycle 4 only; no ret_*; credit 5 then 0; stock 10→9.
- Q, then Q → release one cycle, then ret_d, then ret_n on consecutive cycles; busy high 3 cycles; credit 3→1→0.
- D, N, then cancel → ret_d then ret_n, no release, credit returns to 0. A Q asserted in the cancel cycle → coin_rej=1, credit unaffected.
- STOCK_INIT=1: buy once → sold_out=1. Next N → coin_rej, credit stays 0. restock → sold_out=0, and a subsequent N is accepted (credit=1).
- Q+D+N simultaneously from credit 0 → only Q credited (credit=5), no coin_rej. Coin during CHANGE → coin_rej, change sequence unaltered.
- Q, Q, then rst_n=0 during the first change cycle → next cycle all outputs 0, credit=0, stock=STOCK_INIT, state IDLE.
